// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg
//   Shared flit-format definitions for the NI packet sequencer and its RX
//   framing trackers: the 2-bit flit type encoding, default geometry of a
//   flit and of the packet-size field carried in a HEAD payload, and the
//   TX framing FSM states.
package ravenoc_pkg;

  // Flit type lives in the top two bits of every flit. 2'b11 is not a
  // legal type and is treated as a framing error on RX.
  typedef enum logic [1:0] {
    HEAD = 2'b00,
    BODY = 2'b01,
    TAIL = 2'b10
  } flit_type_t;

  typedef enum logic {
    TX_IDLE,
    TX_BURST
  } tx_state_t;

  localparam int FLIT_TYPE_W     = 2;
  localparam int FLIT_WIDTH_DEF  = 34;
  localparam int FLIT_DATA_DEF   = 32;
  localparam int NUM_VC_DEF      = 2;
  localparam int PKT_WIDTH_DEF   = 8;
  localparam int PKT_POS_MSB_DEF = 31;

endpackage

// File: rtl/pkt_rx_tracker.sv
// pkt_rx_tracker
//   Packet framing tracker for one RX virtual channel. Follows HEAD/BODY/TAIL
//   sequencing using the size field of each HEAD and raises a sticky error on
//   any framing violation. Flits are never dropped: after an error the tracker
//   keeps applying the same rules to whatever arrives next.
// Ports
//   clk, arst_n  clock, async active-low reset
//   sel          a valid flit is presented on this VC
//   upd          that flit is consumed this cycle (sel & downstream ready)
//   ftype        flit type field of the presented flit
//   pkt_sz       size field taken from the presented flit's payload
//   err_clr      synchronous clear of the sticky error
//   sof, eof     presented flit starts / ends a packet (combinational)
//   err          sticky framing error
module pkt_rx_tracker
  import ravenoc_pkg::*;
#(
  parameter int PKT_WIDTH = PKT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 sel,
  input  logic                 upd,
  input  logic [1:0]           ftype,
  input  logic [PKT_WIDTH-1:0] pkt_sz,
  input  logic                 err_clr,
  output logic                 sof,
  output logic                 eof,
  output logic                 err
);

  logic                 active_q, active_d;
  logic [PKT_WIDTH-1:0] rem_q, rem_d;
  logic                 err_set;

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    active_d = active_q;
    rem_d    = rem_q;
    err_set  = 1'b0;
    sof      = sel && (ftype == HEAD);
    eof      = sel && (((ftype == HEAD) && (pkt_sz == '0)) || (ftype == TAIL));
    if (upd) begin
      case (flit_type_t'(ftype))
        HEAD: begin
          err_set  = active_q;
          rem_d    = pkt_sz;
          active_d = (pkt_sz != '0);
        end
        BODY: begin
          // A BODY where the TAIL is due is an error; the count is held so
          // the TAIL that follows still closes the packet cleanly.
          if (!active_q || (rem_q == PKT_WIDTH'(1))) err_set = 1'b1;
          else rem_d = rem_q - PKT_WIDTH'(1);
        end
        TAIL: begin
          err_set  = !active_q || (rem_q != PKT_WIDTH'(1));
          active_d = 1'b0;
          rem_d    = '0;
        end
        default: err_set = 1'b1;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      active_q <= 1'b0;
      rem_q    <= '0;
      err      <= 1'b0;
    end else begin
      active_q <= active_d;
      rem_q    <= rem_d;
      // A new error in the same cycle as a clear must stay visible.
      err      <= err_set | (err & !err_clr);
    end
  end

endmodule

// File: rtl/pkt_proc_seq.sv
// pkt_proc_seq
//   NI packet sequencer between the AXI slave buffers and the router local
//   port.
//   TX: turns a stream of payload words into HEAD/BODY/TAIL flits using the
//   per-packet flit count given with the first word, through one output
//   register stage (1-cycle latency, holds while the router stalls).
//   RX: passes flits through to the AXI side, strips the type field, and
//   tracks packet framing per VC with sticky per-VC error flags.
// Ports
//   clk, arst_n                     clock, async active-low reset
//   tx_valid/tx_ready/tx_data       AXI-side payload word handshake
//   tx_new, tx_pkt_sz, tx_vc        packet start, flits after head, VC
//   tx_err                          sticky TX framing error
//   noc_tx_valid/ready/fdata/vc     flit to router
//   noc_rx_valid/ready/fdata/vc     flit from router
//   rx_valid/ready/data/vc          flit payload to AXI RX buffer
//   rx_sof, rx_eof                  current RX flit starts / ends a packet
//   rx_err                          sticky per-VC RX framing error
//   err_clr                         synchronous clear of tx_err and rx_err
module pkt_proc_seq
  import ravenoc_pkg::*;
#(
  parameter  int FLIT_WIDTH  = FLIT_WIDTH_DEF,
  parameter  int FLIT_DATA   = FLIT_DATA_DEF,
  parameter  int NUM_VC      = NUM_VC_DEF,
  parameter  int PKT_WIDTH   = PKT_WIDTH_DEF,
  parameter  int PKT_POS_MSB = PKT_POS_MSB_DEF,
  localparam int VC_W        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [FLIT_DATA-1:0]  tx_data,
  input  logic                  tx_new,
  input  logic [PKT_WIDTH-1:0]  tx_pkt_sz,
  input  logic [VC_W-1:0]       tx_vc,
  output logic                  tx_err,
  output logic                  noc_tx_valid,
  input  logic                  noc_tx_ready,
  output logic [FLIT_WIDTH-1:0] noc_tx_fdata,
  output logic [VC_W-1:0]       noc_tx_vc,
  input  logic                  noc_rx_valid,
  output logic                  noc_rx_ready,
  input  logic [FLIT_WIDTH-1:0] noc_rx_fdata,
  input  logic [VC_W-1:0]       noc_rx_vc,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [FLIT_DATA-1:0]  rx_data,
  output logic [VC_W-1:0]       rx_vc,
  output logic                  rx_sof,
  output logic                  rx_eof,
  output logic [NUM_VC-1:0]     rx_err,
  input  logic                  err_clr
);

  // ---------------------------------------------------------------- TX ----
  tx_state_t             state_q, state_d;
  logic [PKT_WIDTH-1:0]  rem_q, rem_d;
  logic [VC_W-1:0]       vc_q, vc_d;
  logic [FLIT_WIDTH-1:0] flit_d;
  logic [VC_W-1:0]       flit_vc_d;
  logic                  accept;
  logic                  tx_err_set;

  // The output register can take a new flit when empty or draining this cycle.
  assign tx_ready = !noc_tx_valid | noc_tx_ready;
  assign accept   = tx_valid & tx_ready;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    vc_d       = vc_q;
    flit_vc_d  = vc_q;
    tx_err_set = 1'b0;
    flit_d     = '0;
    flit_d[FLIT_DATA-1:0] = tx_data;
    case (state_q)
      TX_IDLE: begin
        // Every word accepted in IDLE is a HEAD; a word without tx_new is
        // still framed (as a size-0 packet) so the router never sees garbage.
        flit_d[FLIT_WIDTH-1 -: FLIT_TYPE_W] = HEAD;
        flit_d[PKT_POS_MSB -: PKT_WIDTH]    = tx_new ? tx_pkt_sz : '0;
        flit_vc_d = tx_vc;
        if (accept) begin
          if (!tx_new) begin
            tx_err_set = 1'b1;
          end else if (tx_pkt_sz != '0) begin
            state_d = TX_BURST;
            rem_d   = tx_pkt_sz;
            vc_d    = tx_vc;
          end
        end
      end
      TX_BURST: begin
        // The flit counter alone decides framing; tx_new here only flags.
        flit_d[FLIT_WIDTH-1 -: FLIT_TYPE_W] = (rem_q == PKT_WIDTH'(1)) ? TAIL : BODY;
        if (accept) begin
          tx_err_set = tx_new;
          rem_d      = rem_q - PKT_WIDTH'(1);
          if (rem_q == PKT_WIDTH'(1)) state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= TX_IDLE;
      rem_q        <= '0;
      vc_q         <= '0;
      noc_tx_valid <= 1'b0;
      noc_tx_fdata <= '0;
      noc_tx_vc    <= '0;
      tx_err       <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      vc_q    <= vc_d;
      if (accept) begin
        noc_tx_valid <= 1'b1;
        noc_tx_fdata <= flit_d;
        noc_tx_vc    <= flit_vc_d;
      end else if (noc_tx_ready) begin
        noc_tx_valid <= 1'b0;
      end
      tx_err <= tx_err_set | (tx_err & !err_clr);
    end
  end

  // ---------------------------------------------------------------- RX ----
  logic [NUM_VC-1:0] sof_v, eof_v;

  assign noc_rx_ready = rx_ready;
  assign rx_valid     = noc_rx_valid;
  assign rx_data      = noc_rx_fdata[FLIT_DATA-1:0];
  assign rx_vc        = noc_rx_vc;
  // Only the selected tracker can assert sof/eof, so an OR acts as the mux.
  assign rx_sof       = |sof_v;
  assign rx_eof       = |eof_v;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    logic sel;
    assign sel = noc_rx_valid && (noc_rx_vc == VC_W'(i));

    pkt_rx_tracker #(
      .PKT_WIDTH(PKT_WIDTH)
    ) u_trk (
      .clk    (clk),
      .arst_n (arst_n),
      .sel    (sel),
      .upd    (sel & rx_ready),
      .ftype  (noc_rx_fdata[FLIT_WIDTH-1 -: FLIT_TYPE_W]),
      .pkt_sz (noc_rx_fdata[PKT_POS_MSB -: PKT_WIDTH]),
      .err_clr(err_clr),
      .sof    (sof_v[i]),
      .eof    (eof_v[i]),
      .err    (rx_err[i])
    );
  end

endmodule

// File: tb/tb_pkt_proc_seq.sv
// tb_pkt_proc_seq
//   Self-checking bench for pkt_proc_seq: directed scenarios followed by
//   randomized TX and RX traffic, all compared every cycle against a
//   packet-level reference model kept here.
module tb_pkt_proc_seq;
  import ravenoc_pkg::*;

  localparam int FW = 34;
  localparam int FD = 32;
  localparam int NV = 2;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          tx_valid, tx_ready, tx_new, tx_err;
  logic [FD-1:0] tx_data;
  logic [PW-1:0] tx_pkt_sz;
  logic          tx_vc;
  logic          noc_tx_valid, noc_tx_ready;
  logic [FW-1:0] noc_tx_fdata;
  logic          noc_tx_vc;
  logic          noc_rx_valid, noc_rx_ready;
  logic [FW-1:0] noc_rx_fdata;
  logic          noc_rx_vc;
  logic          rx_valid, rx_ready, rx_vc, rx_sof, rx_eof;
  logic [FD-1:0] rx_data;
  logic [NV-1:0] rx_err;
  logic          err_clr;

  always #5 clk = ~clk;

  pkt_proc_seq dut (
    .clk(clk), .arst_n(arst_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_new(tx_new),
    .tx_pkt_sz(tx_pkt_sz), .tx_vc(tx_vc), .tx_err(tx_err),
    .noc_tx_valid(noc_tx_valid), .noc_tx_ready(noc_tx_ready),
    .noc_tx_fdata(noc_tx_fdata), .noc_tx_vc(noc_tx_vc),
    .noc_rx_valid(noc_rx_valid), .noc_rx_ready(noc_rx_ready),
    .noc_rx_fdata(noc_rx_fdata), .noc_rx_vc(noc_rx_vc),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_vc(rx_vc),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err), .err_clr(err_clr)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model ----
  // TX: m_left = flits still owed to the open packet (0 = between packets).
  logic          m_valid;
  logic [FW-1:0] m_flit;
  logic          m_vc;
  int            m_left;
  logic          m_pvc;
  logic          m_tx_err;
  // RX: per-VC packet state.
  bit            r_active[NV];
  int            r_rem[NV];
  logic [NV-1:0] m_rx_err;
  logic          seen_sof, seen_eof;

  function automatic logic [FW-1:0] mk_flit(input logic [1:0] t, input logic [FD-1:0] d);
    return {t, d};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_flit = '0; m_vc = 0; m_left = 0; m_pvc = 0; m_tx_err = 0;
    for (int i = 0; i < NV; i++) begin r_active[i] = 0; r_rem[i] = 0; end
    m_rx_err = '0;
  endtask

  task automatic drive_idle();
    tx_valid = 0; tx_new = 0; tx_data = '0; tx_pkt_sz = '0; tx_vc = 0;
    noc_tx_ready = 1; noc_rx_valid = 0; noc_rx_fdata = '0; noc_rx_vc = 0;
    rx_ready = 1; err_clr = 0;
  endtask

  task automatic rx_flit(input logic [1:0] t, input int sz, input logic vc);
    logic [FD-1:0] d;
    d = $urandom;
    d[31:24] = PW'(sz);
    noc_rx_valid = 1; noc_rx_vc = vc; noc_rx_fdata = mk_flit(t, d);
  endtask

  // Called just after a negedge with inputs driven; checks the cycle and
  // advances the model across the next posedge, returning at the next negedge.
  task automatic step();
    logic          acc, set_tx;
    logic [NV-1:0] set_rx;
    logic [FD-1:0] pay;
    logic [1:0]    t;
    int            v, n;
    #1;
    check("noc_tx_valid", noc_tx_valid, m_valid);
    if (m_valid) begin
      check("noc_tx_fdata", noc_tx_fdata, m_flit);
      check("noc_tx_vc", noc_tx_vc, m_vc);
    end
    check("tx_ready", tx_ready, !m_valid | noc_tx_ready);
    check("tx_err", tx_err, m_tx_err);
    check("rx_err", rx_err, m_rx_err);
    check("rx_valid", rx_valid, noc_rx_valid);
    check("noc_rx_ready", noc_rx_ready, rx_ready);
    t = noc_rx_fdata[33:32];
    n = int'(noc_rx_fdata[31:24]);
    if (noc_rx_valid) begin
      check("rx_data", rx_data, noc_rx_fdata[31:0]);
      check("rx_vc", rx_vc, noc_rx_vc);
      check("rx_sof", rx_sof, t == 2'b00);
      check("rx_eof", rx_eof, (t == 2'b10) || (t == 2'b00 && n == 0));
    end else begin
      check("rx_sof_idle", rx_sof, 1'b0);
      check("rx_eof_idle", rx_eof, 1'b0);
    end
    seen_sof = rx_sof;
    seen_eof = rx_eof;

    // TX packet rules
    acc = tx_valid & (!m_valid | noc_tx_ready);
    set_tx = 0;
    if (acc) begin
      pay = tx_data;
      if (m_left == 0) begin
        pay[31:24] = tx_new ? tx_pkt_sz : '0;
        m_flit = mk_flit(2'b00, pay);
        m_vc = tx_vc;
        if (!tx_new) set_tx = 1;
        else if (tx_pkt_sz != 0) begin m_left = int'(tx_pkt_sz); m_pvc = tx_vc; end
      end else begin
        m_flit = mk_flit((m_left == 1) ? 2'b10 : 2'b01, pay);
        m_vc = m_pvc;
        m_left--;
        if (tx_new) set_tx = 1;
      end
      m_valid = 1;
    end else if (noc_tx_ready) begin
      m_valid = 0;
    end
    m_tx_err = set_tx | (m_tx_err & !err_clr);

    // RX framing rules
    set_rx = '0;
    if (noc_rx_valid && rx_ready) begin
      v = int'(noc_rx_vc);
      case (t)
        2'b00: begin
          if (r_active[v]) set_rx[v] = 1;
          r_rem[v] = n; r_active[v] = (n != 0);
        end
        2'b01: if (!r_active[v] || r_rem[v] == 1) set_rx[v] = 1; else r_rem[v]--;
        2'b10: begin
          if (!r_active[v] || r_rem[v] != 1) set_rx[v] = 1;
          r_active[v] = 0;
        end
        default: set_rx[v] = 1;
      endcase
    end
    m_rx_err = set_rx | (m_rx_err & ~{NV{err_clr}});
    @(negedge clk);
  endtask

  initial begin
    arst_n = 0;
    drive_idle();
    model_reset();
    #1;
    check("rst_noc_tx_valid", noc_tx_valid, 1'b0);
    check("rst_noc_tx_fdata", noc_tx_fdata, '0);
    check("rst_tx_err", tx_err, 1'b0);
    check("rst_rx_err", rx_err, '0);
    @(negedge clk); @(negedge clk);
    arst_n = 1;

    // Size 3 on VC1, tx_valid held, router always ready.
    tx_valid = 1; tx_new = 1; tx_pkt_sz = 3; tx_vc = 1; tx_data = $urandom;
    step();
    check("s3_head_type", noc_tx_fdata[33:32], HEAD);
    check("s3_head_sz", noc_tx_fdata[31:24], 8'd3);
    check("s3_head_vc", noc_tx_vc, 1'b1);
    tx_new = 0; tx_vc = 0; tx_pkt_sz = 7;
    for (int i = 0; i < 3; i++) begin
      tx_data = $urandom;
      step();
      check("s3_body_tail_type", noc_tx_fdata[33:32], (i == 2) ? TAIL : BODY);
      check("s3_vc_latched", noc_tx_vc, 1'b1);
    end

    // Size 0: single HEAD, then another packet start accepted immediately.
    tx_new = 1; tx_pkt_sz = 0; tx_vc = 0; tx_data = $urandom;
    step();
    check("s0_head_sz", noc_tx_fdata[31:24], 8'd0);
    tx_pkt_sz = 2; tx_data = $urandom;
    step();
    check("s0_next_head", noc_tx_fdata[33:32], HEAD);

    // Stall router for 5 cycles mid-burst.
    tx_new = 0; tx_data = $urandom;
    step();
    noc_tx_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tx_data = $urandom;
      step();
      check("stall_tx_ready", tx_ready, 1'b0);
      check("stall_hold_type", noc_tx_fdata[33:32], BODY);
    end
    noc_tx_ready = 1;
    step();
    check("stall_tail", noc_tx_fdata[33:32], TAIL);
    tx_valid = 0;
    step();
    check("tx_no_err", tx_err, 1'b0);

    // RX: TAIL on VC0 with no open packet.
    rx_flit(TAIL, 1, 0);
    step();
    check("orphan_tail_err", rx_err, 2'b01);
    noc_rx_valid = 0; err_clr = 1;
    step();
    err_clr = 0;
    check("orphan_err_clr", rx_err, 2'b00);

    // RX: interleaved packets on both VCs.
    rx_flit(HEAD, 2, 0); step();
    check("ilv_sof_vc0", seen_sof, 1'b1);
    rx_flit(HEAD, 1, 1); step();
    rx_flit(BODY, 0, 0); step();
    rx_flit(TAIL, 0, 1); step();
    check("ilv_eof_vc1", seen_eof, 1'b1);
    rx_flit(TAIL, 0, 0); step();
    check("ilv_eof_vc0", seen_eof, 1'b1);
    noc_rx_valid = 0; step();
    check("ilv_no_err", rx_err, 2'b00);

    // Reset in the middle of a burst (two flits still owed).
    tx_valid = 1; tx_new = 1; tx_pkt_sz = 3; tx_vc = 1; tx_data = $urandom;
    step();
    tx_new = 0; tx_data = $urandom;
    step();
    arst_n = 0;
    model_reset();
    #1;
    check("mid_rst_valid", noc_tx_valid, 1'b0);
    check("mid_rst_fdata", noc_tx_fdata, '0);
    check("mid_rst_vc", noc_tx_vc, 1'b0);
    check("mid_rst_tx_err", tx_err, 1'b0);
    @(negedge clk);
    arst_n = 1;
    tx_new = 1; tx_pkt_sz = 0; tx_vc = 0; tx_data = $urandom;
    step();
    check("post_rst_head", noc_tx_fdata[33:32], HEAD);
    check("post_rst_no_err", tx_err, 1'b0);

    // Randomized traffic on both directions at once.
    for (int c = 0; c < 2000; c++) begin
      int v;
      logic [1:0] t;
      tx_valid     = ($urandom_range(0, 9) < 7);
      tx_new       = (m_left == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      tx_pkt_sz    = PW'($urandom_range(0, 4));
      tx_vc        = 1'($urandom);
      tx_data      = $urandom;
      noc_tx_ready = ($urandom_range(0, 9) < 7);
      rx_ready     = ($urandom_range(0, 9) < 8);
      err_clr      = ($urandom_range(0, 29) == 0);
      v = $urandom_range(0, NV - 1);
      if ($urandom_range(0, 9) == 0) t = 2'($urandom);
      else if (!r_active[v]) t = HEAD;
      else t = (r_rem[v] == 1) ? TAIL : BODY;
      rx_flit(t, $urandom_range(0, 3), 1'(v));
      noc_rx_valid = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
